// File: rtl/test_status_checker_if.sv
// Data-bus port bundle for the test-status peripheral: the CPU side drives
// address/write/read strobes, the peripheral returns registered read data.
interface test_status_checker_if;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        re;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/test_status_checker.sv
// Memory-mapped self-checking test-status peripheral: masked compares, per-channel
// saturating pass/fail counters, hang watchdog and verdict pins.
// Optional macro TEST_STATUS_CHECKER_STOP_ON_FAIL_EN: first mismatch ends the run in FAIL.
module test_status_checker #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  test_status_checker_if.slave  bus,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [15:0]           first_fail_id,
  output logic                  irq
);

`ifdef TEST_STATUS_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t            state, nxt_state;
  logic [15:0]       test_id;
  logic [31:0]       exp_val, mask_val;
  logic [WD_W-1:0]   wd_cnt;
  logic [CNT_W-1:0]  pass_cnt [NUM_CH];
  logic [CNT_W-1:0]  fail_cnt [NUM_CH];

  logic [5:0]  waddr;
  logic [3:0]  act_ch;
  logic        wr, ctrl_wr, start, done_cmd, id_wr, cmp_en, mismatch, wd_expire, fail_set;
  logic [31:0] id_merged, exp_merged, mask_merged, rd_data;
  logic        unused_addr_lsbs;

  function automatic logic [31:0] be_merge(input logic [31:0] cur, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int unsigned b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? nw[8*b +: 8] : cur[8*b +: 8];
    return r;
  endfunction

  assign unused_addr_lsbs = ^bus.addr[1:0];

  always_comb begin
    waddr       = bus.addr[7:2];
    act_ch      = waddr[3:0];
    wr          = |bus.we;
    ctrl_wr     = wr && (waddr == 6'd0) && bus.we[0];
    start       = ctrl_wr && (bus.wdata == 32'd1);
    done_cmd    = ctrl_wr && (bus.wdata == 32'd2);
    // A stopped run freezes TEST_ID so first_fail_id stays meaningful.
    id_wr       = wr && (waddr == 6'd1) && !(STOP_ON_FAIL && state == ST_FAIL);
    cmp_en      = (state == ST_RUN) && (waddr[5:4] == 2'b01) && (bus.we == 4'hF) &&
                  (int'(act_ch) < NUM_CH);
    mismatch    = cmp_en && (((bus.wdata ^ exp_val) & mask_val) != '0);
    wd_expire   = (TIMEOUT_CYCLES != 0) && (state == ST_RUN) && !id_wr && (wd_cnt == WD_LAST);
    fail_set    = mismatch || wd_expire;
    id_merged   = be_merge({16'h0, test_id}, bus.wdata, bus.we);
    exp_merged  = be_merge(exp_val, bus.wdata, bus.we);
    mask_merged = be_merge(mask_val, bus.wdata, bus.we);

    nxt_state = state;
    if (start)
      nxt_state = ST_RUN;
    else if (state == ST_RUN) begin
      if (STOP_ON_FAIL && mismatch)  nxt_state = ST_FAIL;
      else if (done_cmd)             nxt_state = (fail || fail_set) ? ST_FAIL : ST_PASS;
      else if (wd_expire)            nxt_state = ST_TIMEOUT;
    end

    rd_data = '0;
    case (waddr)
      6'd0:    rd_data = {29'b0, state};
      6'd1:    rd_data = {16'h0, test_id};
      6'd2:    rd_data = exp_val;
      6'd3:    rd_data = mask_val;
      default: ;
    endcase
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (waddr == 6'(32 + 2*c)) rd_data = 32'(pass_cnt[c]);
      if (waddr == 6'(33 + 2*c)) rd_data = 32'(fail_cnt[c]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      done          <= 1'b0;
      pass          <= 1'b0;
      irq           <= 1'b0;
      fail          <= 1'b0;
      first_fail_id <= '0;
      test_id       <= '0;
      exp_val       <= '0;
      mask_val      <= '1;
      wd_cnt        <= '0;
      bus.rdata     <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        pass_cnt[c] <= '0;
        fail_cnt[c] <= '0;
      end
    end else begin
      state <= nxt_state;
      done  <= nxt_state inside {ST_PASS, ST_FAIL, ST_TIMEOUT};
      pass  <= (nxt_state == ST_PASS);
      irq   <= (nxt_state != state) && (nxt_state inside {ST_PASS, ST_FAIL, ST_TIMEOUT});

      if (bus.re) bus.rdata <= rd_data;
      if (id_wr) test_id <= id_merged[15:0];
      if (wr && waddr == 6'd2) exp_val  <= exp_merged;
      if (wr && waddr == 6'd3) mask_val <= mask_merged;

      if (start) begin
        fail          <= 1'b0;
        first_fail_id <= '0;
        wd_cnt        <= '0;
      end else begin
        if (fail_set) begin
          fail <= 1'b1;
          if (!fail) first_fail_id <= test_id;
        end
        if (id_wr)                wd_cnt <= '0;
        else if (state == ST_RUN) wd_cnt <= wd_cnt + 1'b1;
      end

      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (start) begin
          pass_cnt[c] <= '0;
          fail_cnt[c] <= '0;
        end else if (cmp_en && act_ch == 4'(c)) begin
          if (!mismatch && pass_cnt[c] != '1) pass_cnt[c] <= pass_cnt[c] + 1'b1;
          if (mismatch && fail_cnt[c] != '1)  fail_cnt[c] <= fail_cnt[c] + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/test_status_checker.md
# test_status_checker

Memory-mapped self-checking test-status peripheral on the Riscv151 data bus. Assembly test programs write test IDs, expected values, masks and observed values into it. The block compares them in hardware, keeps per-channel pass/fail counts, and runs a hang watchdog. It reports an overall verdict on status pins, so long regressions finish without bench-side register peeking.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent check channels (1–16).
- `CNT_W`, 16: width of each per-channel pass and fail counter.
- `TIMEOUT_CYCLES`, 100000: cycles allowed between TEST_ID writes in RUN before a timeout. 0 disables the watchdog.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `addr` in 8: byte address within the block; bits [1:0] ignored.
- `wdata` in 32: write data.
- `we` in 4: byte write enables.
- `re` in 1: read strobe.
- `rdata` out 32: read data, registered.
- `done` out 1: verdict reached (PASS, FAIL or TIMEOUT state).
- `pass` out 1: state is PASS.
- `fail` out 1: sticky; set on the first mismatch or on timeout.
- `first_fail_id` out 16: TEST_ID at the first failure.
- `irq` out 1: one-cycle pulse on entry to any verdict state.

## Operation
- Register map (word offsets):
  - 0x00 CTRL: write 1 = START, write 2 = DONE. Reads back {29'b0, state}.
  - 0x04 TEST_ID: [15:0].
  - 0x08 EXPECT.
  - 0x0C MASK, reset 0xFFFF_FFFF.
  - 0x40+4·ch: ACTUAL for channel ch.
  - 0x80+8·ch: PASS_CNT for channel ch.
  - 0x84+8·ch: FAIL_CNT for channel ch.
- Unmapped addresses: reads return 0, writes are ignored.
- State machine: IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
  - IDLE→RUN on START.
  - RUN→PASS on DONE with fail=0; RUN→FAIL on DONE with fail=1.
  - RUN→TIMEOUT on watchdog expiry.
  - START from any state re-enters RUN and clears all counters, `fail`, `first_fail_id` and the watchdog.
  - DONE outside RUN is ignored.
- EXPECT, MASK and TEST_ID honour byte enables.
- A compare fires only on a full-word write to ACTUAL (`we`=4'hF) while in RUN. Partial ACTUAL writes, and ACTUAL writes outside RUN, are dropped.
- Compare rule: (wdata & MASK) == (EXPECT & MASK).
  - Equal: that channel's PASS_CNT increments.
  - Not equal: FAIL_CNT increments and `fail` sets. If `fail` was previously 0, TEST_ID is captured into `first_fail_id`.
- Counters saturate at all-ones and never wrap.
- Watchdog: counts RUN cycles and reloads to 0 on every TEST_ID write. Expiry occurs when the count reaches TIMEOUT_CYCLES−1. Expiry sets `fail` and captures TEST_ID if `fail` was previously 0.
- Simultaneous events:
  - A TEST_ID write in the expiry cycle reloads the watchdog; no timeout.
  - A compare in the same cycle as DONE is counted first. The verdict uses the updated `fail`.

## Timing
- Reset values: `rdata`=0, `done`=0, `pass`=0, `fail`=0, `first_fail_id`=0, `irq`=0, state IDLE. All counters and registers are 0 except MASK.
- Read latency is 1 cycle. `rdata` holds its value when `re`=0.
- Register and counter updates are visible on the cycle after the write edge.
- State and status outputs change on the clock edge after the triggering write.
- `irq` is high for exactly that one cycle.
- Reset asserted mid-run returns everything to reset values asynchronously.

## Configuration
- `TEST_STATUS_CHECKER_STOP_ON_FAIL_EN`:
  - Defined: the first mismatch moves RUN→FAIL on the next edge, with `irq`. Later compares and TEST_ID writes are ignored until START.
  - Undefined: mismatches are only counted. RUN continues until DONE or timeout.

## Test plan
- Basic pass: START, EXPECT=0x1122_3344, MASK=0xFFFF_FFFF, ACTUAL[0]=0x1122_3344, DONE → PASS_CNT0=1, `pass`=1, `done`=1, one `irq` pulse.
- Masked mismatch: MASK=0x0000_FFFF, EXPECT=0xAAAA_3344, ACTUAL[2]=0x5555_3344 → pass. Then MASK=0xFFFF_FFFF → FAIL_CNT2=1, `fail`=1, `first_fail_id`=current TEST_ID (e.g. 6).
- Partial write and saturation: ACTUAL[1] written with `we`=4'h3 → no counter change. With CNT_W=4, 17 matching writes → PASS_CNT1=0xF.
- Watchdog: TIMEOUT_CYCLES=50, START, no TEST_ID writes → state TIMEOUT at cycle 50, `fail`=1. A TEST_ID write every 49 cycles → never times out.
- Stop-on-fail, macro defined: mismatch at TEST_ID=3, then a matching compare → state FAIL, PASS_CNT unchanged. Macro undefined → state RUN, PASS_CNT incremented.
- Reset mid-run: pull `rst` low after 2 compares → all outputs and counters read 0 immediately; state IDLE.
